// File: rtl/matrix_addr_pkg.sv
// Shared types and constants for the matrix address generator.
//   state_t              : sweep controller states
//   DEF_ADDR_W/DEF_LANES : default word-address width and lanes per beat
//   LEGACY_BASE/LEN      : fixed sweep window of the original 128x128 path
package matrix_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_LANES  = 8;

    localparam int unsigned LEGACY_BASE = 32'h3000;
    localparam int unsigned LEGACY_LEN  = 32'h1000;

endpackage

// File: rtl/matrix_addr_gen_if.sv
// Handshake/bus bundle between the address generator and its controller/consumer.
//   start/base_i/len_i : sweep request, sampled when start is accepted
//   abort              : terminate the current sweep
//   ready              : consumer accepts the current beat
//   valid/addr_o/lane_mask/last : beat; lane i at addr_o[i*ADDR_W +: ADDR_W]
//   busy/done          : status levels
// slave  : the generator side; master : the controller/consumer side.
interface matrix_addr_gen_if
    import matrix_addr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES,
    parameter int LEN_W  = ADDR_W + 1
) ();

    logic                      start;
    logic [ADDR_W-1:0]         base_i;
    logic [LEN_W-1:0]          len_i;
    logic                      abort;
    logic                      ready;
    logic                      valid;
    logic [LANES*ADDR_W-1:0]   addr_o;
    logic [LANES-1:0]          lane_mask;
    logic                      last;
    logic                      busy;
    logic                      done;

    modport slave (
        input  start, base_i, len_i, abort, ready,
        output valid, addr_o, lane_mask, last, busy, done
    );

    modport master (
        output start, base_i, len_i, abort, ready,
        input  valid, addr_o, lane_mask, last, busy, done
    );

endinterface

// File: rtl/matrix_addr_gen.sv
// Multi-lane address generator: walks len_i words starting at base_i, LANES
// consecutive word addresses per beat, with a lane mask on the final beat.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : matrix_addr_gen_if.slave (request, abort, beat handshake, status)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no sweep; waiting for start
// ST_RUN  | presenting beats at cur, rem words still to issue
// ST_DONE | sweep finished; done held high until start or abort
module matrix_addr_gen
    import matrix_addr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    matrix_addr_gen_if.slave  bus
);

    localparam logic [LEN_W-1:0]  LANES_LEN  = LEN_W'(LANES);
    localparam logic [ADDR_W-1:0] LANES_ADDR = ADDR_W'(LANES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [LEN_W-1:0]    rem_q, rem_d;

    logic                     is_last;
    logic [LANES*ADDR_W-1:0]  lane_addr;
    logic [LANES-1:0]         lane_hit;

    assign is_last = (rem_q <= LANES_LEN);

    // Masked lanes still carry cur+i; the sum wraps naturally at ADDR_W bits.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_addr[i*ADDR_W +: ADDR_W] = cur_q + ADDR_W'(i);
        assign lane_hit[i]                   = (rem_q > LEN_W'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort beats a coincident start
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    if (bus.len_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        cur_d   = bus.base_i;
                        rem_d   = bus.len_i;
                    end
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.ready) begin
                    cur_d = cur_q + LANES_ADDR;
                    // final beat may be partial; clamp so rem never underflows
                    rem_d = is_last ? '0 : (rem_q - LANES_LEN);
                    if (is_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs depend only on flops; beat fields are zeroed outside RUN.
    always_comb begin
        bus.valid     = (state_q == ST_RUN);
        bus.busy      = (state_q == ST_RUN);
        bus.done      = (state_q == ST_DONE);
        bus.last      = 1'b0;
        bus.lane_mask = '0;
        bus.addr_o    = '0;
        if (state_q == ST_RUN) begin
            bus.last      = is_last;
            bus.lane_mask = lane_hit;
            bus.addr_o    = lane_addr;
        end
    end

endmodule

// File: tb/tb_matrix_addr_gen.sv
module tb_matrix_addr_gen;
    import matrix_addr_pkg::*;

    localparam int ADDR_W = 14;
    localparam int LANES  = 8;
    localparam int LEN_W  = ADDR_W + 1;

    typedef struct {
        logic [LANES*ADDR_W-1:0] addr;
        logic [LANES-1:0]        mask;
        logic                    last;
    } beat_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   beats_seen;
    beat_t exp_q[$];

    matrix_addr_gen_if #(.ADDR_W(ADDR_W), .LANES(LANES), .LEN_W(LEN_W)) bus ();

    matrix_addr_gen #(.ADDR_W(ADDR_W), .LANES(LANES), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model of one sweep, queued when the sweep is requested.
    function automatic void push_sweep(input logic [ADDR_W-1:0] base, input int len);
        logic [ADDR_W-1:0] cur;
        int rem;
        beat_t b;
        cur = base;
        rem = len;
        while (rem > 0) begin
            for (int i = 0; i < LANES; i++) begin
                b.addr[i*ADDR_W +: ADDR_W] = cur + ADDR_W'(i);
                b.mask[i] = (i < rem);
            end
            b.last = (rem <= LANES);
            exp_q.push_back(b);
            cur = cur + ADDR_W'(LANES);
            rem = (rem > LANES) ? rem - LANES : 0;
        end
    endfunction

    // Scoreboard consumer: a beat transfers at the next edge when valid && ready.
    always @(negedge clk) begin
        if (!reset && bus.valid && bus.ready) begin
            beat_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got addr0=%h mask=%h last=%b, required no beat",
                         bus.addr_o[ADDR_W-1:0], bus.lane_mask, bus.last);
            end else begin
                e = exp_q.pop_front();
                beats_seen++;
                if (bus.addr_o !== e.addr || bus.lane_mask !== e.mask || bus.last !== e.last) begin
                    n_fail++;
                    $display("FAIL beat_%0d: got addr=%h mask=%h last=%b, required addr=%h mask=%h last=%b",
                             beats_seen - 1, bus.addr_o, bus.lane_mask, bus.last, e.addr, e.mask, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base, input int len);
        bus.start  = 1'b1;
        bus.base_i = base;
        bus.len_i  = LEN_W'(len);
        step();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < budget) begin
            step();
            cycles++;
        end
        n_checks++;
        if (!bus.done) begin
            n_fail++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.valid, bus.addr_o, bus.lane_mask, bus.last, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b addr=%h mask=%h last=%b busy=%b done=%b, required all 0",
                     bus.valid, bus.addr_o, bus.lane_mask, bus.last, bus.busy, bus.done);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_legacy();
        int cyc;
        bus.ready  = 1'b1;
        beats_seen = 0;
        push_sweep(ADDR_W'(LEGACY_BASE), int'(LEGACY_LEN));
        do_start(ADDR_W'(LEGACY_BASE), int'(LEGACY_LEN));
        n_checks++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b1 || bus.addr_o[0 +: ADDR_W] !== 14'h3000 ||
            bus.addr_o[7*ADDR_W +: ADDR_W] !== 14'h3007) begin
            n_fail++;
            $display("FAIL legacy_first: got valid=%b busy=%b lane0=%h lane7=%h, required 1 1 3000 3007",
                     bus.valid, bus.busy, bus.addr_o[0 +: ADDR_W], bus.addr_o[7*ADDR_W +: ADDR_W]);
        end
        wait_done(600, cyc);
        n_checks++;
        if (cyc != 512 || beats_seen != 512 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL legacy_count: got cycles=%0d beats=%0d left=%0d, required 512 512 0",
                     cyc, beats_seen, exp_q.size());
        end
        n_checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL legacy_end: got valid=%b busy=%b done=%b, required 0 0 1",
                     bus.valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_partial();
        int cyc;
        beats_seen = 0;
        push_sweep(14'h0100, 13);
        do_start(14'h0100, 13);
        n_checks++;
        if (bus.lane_mask !== 8'hFF || bus.last !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_beat0: got mask=%h last=%b, required ff 0", bus.lane_mask, bus.last);
        end
        step();
        n_checks++;
        if (bus.lane_mask !== 8'h1F || bus.last !== 1'b1 || bus.addr_o[0 +: ADDR_W] !== 14'h0108 ||
            bus.addr_o[7*ADDR_W +: ADDR_W] !== 14'h010F) begin
            n_fail++;
            $display("FAIL partial_beat1: got mask=%h last=%b lane0=%h lane7=%h, required 1f 1 0108 010f",
                     bus.lane_mask, bus.last, bus.addr_o[0 +: ADDR_W], bus.addr_o[7*ADDR_W +: ADDR_W]);
        end
        wait_done(4, cyc);
        n_checks++;
        if (beats_seen != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL partial_count: got beats=%0d left=%0d, required 2 0", beats_seen, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int cyc;
        beats_seen = 0;
        push_sweep(14'h3FFC, 8);
        do_start(14'h3FFC, 8);
        n_checks++;
        if (bus.addr_o[3*ADDR_W +: ADDR_W] !== 14'h3FFF || bus.addr_o[4*ADDR_W +: ADDR_W] !== 14'h0000 ||
            bus.addr_o[7*ADDR_W +: ADDR_W] !== 14'h0003 || bus.lane_mask !== 8'hFF || bus.last !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_beat: got lane3=%h lane4=%h lane7=%h mask=%h last=%b, required 3fff 0000 0003 ff 1",
                     bus.addr_o[3*ADDR_W +: ADDR_W], bus.addr_o[4*ADDR_W +: ADDR_W],
                     bus.addr_o[7*ADDR_W +: ADDR_W], bus.lane_mask, bus.last);
        end
        wait_done(4, cyc);
        n_checks++;
        if (cyc != 1 || beats_seen != 1) begin
            n_fail++;
            $display("FAIL wrap_count: got cycles=%0d beats=%0d, required 1 1", cyc, beats_seen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        beats_seen = 0;
        push_sweep(14'h2000, 16);
        do_start(14'h2000, 16);
        n_checks++;
        if (bus.done !== 1'b0 || bus.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got done=%b valid=%b, required 0 1", bus.done, bus.valid);
        end
        wait_done(4, cyc);
        n_checks++;
        if (cyc != 2 || beats_seen != 2) begin
            n_fail++;
            $display("FAIL restart_count: got cycles=%0d beats=%0d, required 2 2", cyc, beats_seen);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        beats_seen = 0;
        push_sweep(14'h0200, 32);
        do_start(14'h0200, 32);
        step();
        step();
        bus.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (bus.valid !== 1'b1 || bus.addr_o[0 +: ADDR_W] !== 14'h0210 ||
                bus.addr_o[7*ADDR_W +: ADDR_W] !== 14'h0217 || bus.lane_mask !== 8'hFF || bus.last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got valid=%b lane0=%h lane7=%h mask=%h last=%b, required 1 0210 0217 ff 0",
                         k, bus.valid, bus.addr_o[0 +: ADDR_W], bus.addr_o[7*ADDR_W +: ADDR_W],
                         bus.lane_mask, bus.last);
            end
        end
        bus.ready = 1'b1;
        wait_done(6, cyc);
        n_checks++;
        if (beats_seen != 4 || exp_q.size() != 0 || cyc != 2) begin
            n_fail++;
            $display("FAIL bp_count: got beats=%0d left=%0d cycles=%0d, required 4 0 2",
                     beats_seen, exp_q.size(), cyc);
        end
    endtask

    task automatic test_zero_and_start_in_run();
        int cyc;
        beats_seen = 0;
        do_start(14'h1111, 0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: got done=%b valid=%b busy=%b, required 1 0 0", bus.done, bus.valid, bus.busy);
        end
        push_sweep(14'h0400, 24);
        do_start(14'h0400, 24);
        do_start(14'h1234, 5);
        wait_done(6, cyc);
        n_checks++;
        if (beats_seen != 3 || exp_q.size() != 0 || cyc != 2) begin
            n_fail++;
            $display("FAIL start_in_run: got beats=%0d left=%0d cycles=%0d, required 3 0 2",
                     beats_seen, exp_q.size(), cyc);
        end
    endtask

    task automatic test_abort_reset();
        int cyc;
        beats_seen = 0;
        push_sweep(14'h0800, 64);
        do_start(14'h0800, 64);
        step();
        step();
        step();
        bus.ready = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || beats_seen != 3) begin
            n_fail++;
            $display("FAIL abort_run: got valid=%b done=%b busy=%b beats=%0d, required 0 0 0 3",
                     bus.valid, bus.done, bus.busy, beats_seen);
        end
        exp_q.delete();
        bus.ready  = 1'b1;
        beats_seen = 0;
        push_sweep(14'h0900, 8);
        do_start(14'h0900, 8);
        wait_done(4, cyc);
        n_checks++;
        if (beats_seen != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_restart: got beats=%0d left=%0d, required 1 0", beats_seen, exp_q.size());
        end
        bus.abort = 1'b1;
        do_start(14'h0A00, 8);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_vs_start: got valid=%b done=%b busy=%b, required 0 0 0",
                     bus.valid, bus.done, bus.busy);
        end
        push_sweep(14'h0B00, 64);
        do_start(14'h0B00, 64);
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({bus.valid, bus.addr_o, bus.lane_mask, bus.last, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_sweep: got valid=%b addr=%h mask=%h last=%b busy=%b done=%b, required all 0",
                     bus.valid, bus.addr_o, bus.lane_mask, bus.last, bus.busy, bus.done);
        end
        reset = 1'b0;
        exp_q.delete();
        step();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        beats_seen = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.base_i = '0;
        bus.len_i  = '0;
        bus.abort  = 1'b0;
        bus.ready  = 1'b0;
        test_reset();
        test_legacy();
        test_partial();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_zero_and_start_in_run();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_addr_gen.md
# matrix_addr_gen

Parametrised multi-lane address generator for the matrix-multiply datapath. It walks a contiguous block of matrix memory starting at a run-time base address. Each beat it emits LANES consecutive word addresses, with a per-lane valid mask for a partial final beat. It adds a start/ready/done handshake, a run-time base and length, back-pressure, abort, and address wrap-around, and generalises the fixed 8-lane, fixed-window sweep counters used in the 128x128 path.

## Interface
- ADDR_W, 14, word-address width; all address arithmetic is modulo 2^ADDR_W.
- LANES, 8, addresses issued per beat; power of two, 1..32.
- LEN_W, ADDR_W+1, width of the length input; must express 2^ADDR_W words.
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- base_i  in  ADDR_W  first word address; sampled when start is accepted.
- len_i  in  LEN_W  number of words to issue; sampled when start is accepted.
- abort  in  1  terminate the current sweep; takes effect next cycle.
- ready  in  1  consumer accepts the current beat.
- valid  out  1  beat present on addr_o/lane_mask.
- addr_o  out  LANES*ADDR_W  lane i occupies bits [i*ADDR_W +: ADDR_W].
- lane_mask  out  LANES  bit i set means lane i carries a real address.
- last  out  1  current beat is the final beat of the sweep.
- busy  out  1  state is RUN.
- done  out  1  level; high while in DONE.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** state IDLE; cur and rem are 0. Outputs: valid=0, addr_o=0, lane_mask=0, last=0, busy=0, done=0.
- **IDLE/DONE + start, len_i>0:** load cur=base_i, rem=len_i, go to RUN.
- **IDLE/DONE + start, len_i=0:** go to DONE; no beat is issued.
- **start while in RUN:** ignored.
- **Beat contents in RUN:**
  - valid=1.
  - addr_o lane i = (cur+i) mod 2^ADDR_W.
  - lane_mask[i] = (i < rem).
  - last = (rem <= LANES).
- **Handshake:** a beat transfers when valid && ready.
  - On transfer: cur += LANES (wraps), rem -= min(LANES, rem).
  - If last, go to DONE.
- **Back-pressure:** while ready=0, addr_o, lane_mask and last hold stable.
- **Masked lanes:** lanes with lane_mask=0 still drive cur+i; consumers must ignore them.
- **abort:**
  - In RUN: go to IDLE next cycle and clear valid; done does not assert.
  - In DONE: go to IDLE.
  - abort and start in the same cycle: abort wins and start is dropped.
- **reset:** overrides everything, including mid-sweep.

## Timing
- All outputs are registered and are functions of state, cur and rem only; no combinational input-to-output path.
- **First beat:** start accepted at edge N gives valid=1 in the cycle after edge N.
- **Throughput:** with ready held high, one beat per cycle; a sweep takes ceil(len_i/LANES) cycles in RUN.
- **End of sweep:** the edge that transfers the last beat moves to DONE. In the following cycle valid=0, done=1 and busy=0.
- **Restart:** start in DONE gives done=0 and valid=1 in the next cycle, so back-to-back sweeps have a one-cycle gap.
- **Zero length:** len_i=0 gives done=1 one cycle after start.
- **Counter widths:** rem is LEN_W bits and never underflows. cur wraps silently from 2^ADDR_W-1 to 0, including wraps within a single beat.

## Structure
- Package matrix_addr_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default ADDR_W and LANES localparams;
  - the legacy window constants: base 'h3000, length 'h1000.
- No sub-module. Lane address adders and the mask compare are generate loops inside matrix_addr_gen.

## Test plan
- **Legacy window:** base 'h3000, len 'h1000, LANES=8, ready=1.
  - 512 beats: first beat 'h3000..'h3007, last beat 'h3ff8..'h3fff with mask 'hFF and last=1.
  - done=1 the next cycle.
- **Partial final beat:** base 'h0100, len 13.
  - Beat 0: mask 'hFF, last=0.
  - Beat 1: addresses 'h0108..'h010F, mask 'h1F, last=1.
- **Wrap-around:** base 'h3FFC, len 8.
  - One beat with addresses 'h3FFC, 'h3FFD, 'h3FFE, 'h3FFF, 'h0000..'h0003, mask 'hFF.
- **Back-pressure:** ready low for 3 cycles on beat 2 of a 4-beat sweep.
  - Beat 2's outputs hold stable; total beats=4, no duplicates, no skips.
- **Zero length and start in RUN:**
  - len 0 gives done=1 with no valid.
  - A start pulse mid-sweep does not change base or remaining count.
- **Abort and reset mid-sweep:**
  - abort on beat 3 gives IDLE, valid=0, done=0 next cycle; a new start runs cleanly.
  - reset mid-sweep returns every output to 0 next cycle.
